// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC pass sequencer.
//   CH_W    - width of the passes-per-pixel config
//   PSUM_W  - saturated partial-sum width (pre_output / out_data)
//   BIAS_W  - bias width fed to addertree_stage1
//   state_e - sequencer states
//   sat_psum() - clamps a (PSUM_W+1)-bit final-adder result to PSUM_W bits
package mac_pkg;

    localparam int CH_W   = 8;
    localparam int PSUM_W = 13;
    localparam int BIAS_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // The top two bits disagreeing means the value left the PSUM_W range.
    function automatic logic [PSUM_W-1:0] sat_psum(input logic [PSUM_W:0] x);
        case (x[PSUM_W:PSUM_W-1])
            2'b01:   return {1'b0, {(PSUM_W-1){1'b1}}};
            2'b10:   return {1'b1, {(PSUM_W-1){1'b0}}};
            default: return x[PSUM_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/psum_sat.sv
// psum_sat: combinational clamp of the final-adder result to the partial-sum width.
//   x_i  in  PSUM_W+1  signed final-adder output
//   y_o  out PSUM_W    signed saturated partial sum
module psum_sat
    import mac_pkg::*;
(
    input  logic [PSUM_W:0]   x_i,
    output logic [PSUM_W-1:0] y_o
);

    assign y_o = sat_psum(x_i);

endmodule

// File: rtl/mac_pass_sequencer.sv
// mac_pass_sequencer: runs the multiplier/addertree/adder_final datapath over several
// input-channel passes per output pixel and hands out one saturated sum per pixel.
//   clk, reset           clock, synchronous active-low reset
//   cfg_ch_num, cfg_bias passes per pixel / pixel bias, taken on a pixel's first pass
//   in_valid, in_ready   pass handshake with the operand fetch stage
//   at_bias              bias into addertree_stage1 (first pass only)
//   at_pre_output        running partial sum into addertree_stage2
//   at_out               adder_final result, same cycle
//   out_valid, out_ready, out_data  finished-pixel handshake to the output writer
//   busy                 sequencer is not idle
module mac_pass_sequencer
    import mac_pkg::*;
#(
    parameter int CH_W = mac_pkg::CH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_W-1:0]   cfg_ch_num,
    input  logic [BIAS_W-1:0] cfg_bias,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BIAS_W-1:0] at_bias,
    output logic [PSUM_W-1:0] at_pre_output,
    input  logic [PSUM_W:0]   at_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_data,
    output logic              busy
);

    state_e            state_q;
    logic [CH_W-1:0]   cnt_q;
    logic [CH_W-1:0]   n_q;
    logic [PSUM_W-1:0] psum_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [PSUM_W-1:0] sat_val;
    logic [CH_W-1:0]   n_first;
    logic [CH_W-1:0]   cnt_inc;

    psum_sat u_sat (
        .x_i (at_out),
        .y_o (sat_val)
    );

    // A zero pass count still runs one pass.
    assign n_first = (cfg_ch_num == '0) ? CH_W'(1) : cfg_ch_num;
    assign cnt_inc = cnt_q + CH_W'(1);

    // The bias only enters on a pixel's first pass, which is always driven
    // straight from cfg_bias, so it needs no holding register.
    always_comb begin
        in_ready      = 1'b1;
        at_bias       = cfg_bias;
        at_pre_output = '0;
        case (state_q)
            ACC: begin
                at_bias       = '0;
                at_pre_output = psum_q;
            end
            HOLD:    in_ready = out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            psum_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    // HOLD with out_ready low stalls everything; otherwise HOLD
                    // retires its pixel and behaves exactly like IDLE.
                    if (state_q != HOLD || out_ready) begin
                        if (in_valid) begin
                            n_q    <= n_first;
                            psum_q <= sat_val;
                            cnt_q  <= CH_W'(1);
                            busy_q <= 1'b1;
                            if (n_first == CH_W'(1)) begin
                                state_q     <= HOLD;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q     <= ACC;
                                out_valid_q <= 1'b0;
                            end
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        psum_q <= sat_val;
                        cnt_q  <= cnt_inc;
                        if (cnt_inc == n_q) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // psum only changes on an accepted pass, so it is stable through a HOLD stall.
    assign out_data  = psum_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_pass_sequencer.sv
module tb_mac_pass_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        cfg_ch_num;
    logic [15:0]       cfg_bias;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       at_bias;
    logic [12:0]       at_pre_output;
    logic [13:0]       at_out;
    logic              out_valid;
    logic              out_ready;
    logic [12:0]       out_data;
    logic              busy;
    logic signed [7:0] a, b;

    int n_chk = 0;
    int n_fail = 0;
    bit started = 0;

    always #5 clk = ~clk;

    mac_pass_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_ch_num    (cfg_ch_num),
        .cfg_bias      (cfg_bias),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .at_bias       (at_bias),
        .at_pre_output (at_pre_output),
        .at_out        (at_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
    );

    // Stand-in for multiplier + addertree + adder_final: a 14-bit result window,
    // wide enough that the sequencer's own clamp does the saturating.
    int raw;
    always_comb begin
        raw = 9 * int'(a) * int'(b) + int'($signed(at_bias)) + int'($signed(at_pre_output)) * 64;
        if (raw > 524287) raw = 524287;
        if (raw < -524288) raw = -524288;
        at_out = 14'(raw >>> 6);
    end

    // Golden pass result: clamp to 19 bits, keep bits [18:6].
    function automatic int golden(input int ga, input int gb, input int gbias, input int gpre);
        int o;
        o = 9 * ga * gb + gbias + gpre * 64;
        if (o > 262143) o = 262143;
        if (o < -262144) o = -262144;
        return o >>> 6;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel-level model: passes done on the current pixel, its running sum,
    // and at most one finished pixel waiting for the writer.
    int  m_k = 0, m_n = 0, m_acc = 0, m_out = 0;
    bit  m_has_out = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_k = 0; m_n = 0; m_acc = 0; m_out = 0; m_has_out = 0;
        end else begin
            bit rdy;
            bit first;
            rdy = m_has_out ? out_ready : 1'b1;
            if (m_has_out && out_ready) m_has_out = 0;
            if (in_valid && rdy) begin
                first = (m_k == 0);
                if (first) m_n = (cfg_ch_num == 0) ? 1 : int'(cfg_ch_num);
                m_acc = golden(int'(a), int'(b), first ? int'($signed(cfg_bias)) : 0,
                               first ? 0 : m_acc);
                m_k++;
                if (m_k == m_n) begin
                    m_has_out = 1;
                    m_out = m_acc;
                    m_k = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", int'(in_ready), m_has_out ? int'(out_ready) : 1);
            chk("out_valid", int'(out_valid), int'(m_has_out));
            chk("busy", int'(busy), int'(m_has_out || m_k > 0));
            chk("at_bias", int'(at_bias), (m_k > 0) ? 0 : int'(cfg_bias));
            chk("at_pre_output", int'($signed(at_pre_output)), (m_k > 0) ? m_acc : 0);
            if (m_has_out) chk("out_data", int'($signed(out_data)), m_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; cfg_ch_num = '0; cfg_bias = '0; in_valid = 1'b0;
        out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        started = 1;
        reset = 1'b1;
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);

        // single-pass pixel
        cfg_ch_num = 8'd1; a = 8'sd16; b = 8'sd16; in_valid = 1'b1;
        tick();
        chk("t1 out_valid", int'(out_valid), 1);
        chk("t1 out_data", int'($signed(out_data)), 36);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t1 busy after retire", int'(busy), 0);
        out_ready = 1'b0;

        // three passes, in_valid held
        cfg_ch_num = 8'd3; in_valid = 1'b1;
        tick();
        chk("t2 pre1", int'($signed(at_pre_output)), 36);
        chk("t2 valid1", int'(out_valid), 0);
        tick();
        chk("t2 pre2", int'($signed(at_pre_output)), 72);
        tick();
        chk("t2 out_valid", int'(out_valid), 1);
        chk("t2 out_data", int'($signed(out_data)), 108);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // saturation on the second pass
        cfg_ch_num = 8'd2; a = -8'sd128; b = -8'sd128; in_valid = 1'b1;
        tick();
        chk("t3 pre1", int'($signed(at_pre_output)), 2304);
        tick();
        chk("t3 out_data", int'($signed(out_data)), 4095);

        // stall in HOLD, then bubble-free handoff
        cfg_ch_num = 8'd1; a = 8'sd16; b = 8'sd16;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4 in_ready stall", int'(in_ready), 0);
            tick();
            chk("t4 data stable", int'($signed(out_data)), 4095);
        end
        out_ready = 1'b1;
        #1 chk("t4 in_ready", int'(in_ready), 1);
        tick();
        chk("t4 handoff valid", int'(out_valid), 1);
        chk("t4 handoff data", int'($signed(out_data)), 36);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // zero pass count, then config change mid-pixel
        cfg_ch_num = 8'd0; in_valid = 1'b1;
        tick();
        chk("t5 n0 valid", int'(out_valid), 1);
        chk("t5 n0 data", int'($signed(out_data)), 36);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cfg_ch_num = 8'd2; in_valid = 1'b1;
        tick();
        cfg_ch_num = 8'd5; cfg_bias = 16'd1000;
        #1 chk("t5 at_bias acc", int'(at_bias), 0);
        tick();
        chk("t5 cfg ignored valid", int'(out_valid), 1);
        chk("t5 cfg ignored data", int'($signed(out_data)), 72);
        in_valid = 1'b0; out_ready = 1'b1; cfg_bias = '0;
        tick();
        out_ready = 1'b0;

        // reset mid-pixel
        cfg_ch_num = 8'd4; in_valid = 1'b1;
        tick(); tick();
        chk("t6 pre2", int'($signed(at_pre_output)), 72);
        reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        chk("t6 rst valid", int'(out_valid), 0);
        chk("t6 rst busy", int'(busy), 0);
        chk("t6 rst data", int'(out_data), 0);
        cfg_ch_num = 8'd1; cfg_bias = 16'd64; in_valid = 1'b1;
        tick();
        chk("t6 fresh data", int'($signed(out_data)), 37);
        in_valid = 1'b0; out_ready = 1'b1; cfg_bias = '0;
        tick();
        out_ready = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 399) != 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            a          = 8'($urandom_range(0, 255));
            b          = 8'($urandom_range(0, 255));
            cfg_bias   = 16'($urandom_range(0, 65535));
            cfg_ch_num = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 4));
            tick();
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
